spi_lcd_rx: RTL and testbench
=============================

SPI_LCD_RX -- requirements
Module: spi_lcd_rx

Interface
REQ-001 The module SHALL have parameter FifoDepth, default 4, giving the number of received-byte entries buffered (power of two, 2..16).
REQ-002 The module SHALL have parameter SyncStages, default 2, giving the synchroniser flops per SPI input (2 or 3).
REQ-003 clk_sys_i  in  1  system clock; the only clock in the block; SPI inputs are oversampled and never used as clocks.
REQ-004 rst_sys_i  in  1  asynchronous, active-high reset.
REQ-005 spi_sck_i  in  1  SPI serial clock from the controller; mode 0 (CPOL=0, CPHA=0).
REQ-006 spi_cs_ni  in  1  chip select, active low.
REQ-007 spi_copi_i  in  1  serial data, MSB first.
REQ-008 spi_dc_i  in  1  LCD data/command flag (1 = data, 0 = command), sampled with bit 0 of each byte.
REQ-009 byte_o  out  8  head-of-FIFO received byte.
REQ-010 dc_o  out  1  dc flag associated with byte_o.
REQ-011 valid_o  out  1  FIFO non-empty; byte_o/dc_o valid.
REQ-012 ready_i  in  1  consumer accepts head entry when valid_o && ready_i on a rising clk_sys_i.
REQ-013 level_o  out  clog2(FifoDepth)+1  current FIFO occupancy.
REQ-014 frame_err_o  out  1  one-cycle pulse: chip select released mid-byte.
REQ-015 ovf_cnt_o  out  8  saturating count of bytes dropped because the FIFO was full.

Function
REQ-016 Each SPI input SHALL pass through SyncStages flops; synchroniser reset values: sck 0, cs_n 1, copi 0, dc 0.
REQ-017 An sck rising edge SHALL be detected as synchronised sck = 1 while its one-cycle-delayed copy = 0; falling edges are ignored.
REQ-018 States SHALL be IDLE (synced cs_n = 1) and SHIFT (synced cs_n = 0); IDLE->SHIFT on synced cs_n falling, SHIFT->IDLE on synced cs_n rising.
REQ-019 Entering SHIFT SHALL clear the 3-bit bit counter and the shift register.
REQ-020 In SHIFT, each detected sck rising edge SHALL shift synced copi into the LSB of the shift register and increment the bit counter modulo 8.
REQ-021 On the edge where the bit counter wraps 7->0, the 8-bit value (including the bit just sampled) and synced dc SHALL be registered as a completed byte and pushed into the FIFO on the next clk_sys_i edge.
REQ-022 Latency: valid_o SHALL rise exactly SyncStages+2 clk_sys_i rising edges after the first clk_sys_i edge that samples spi_sck_i high for bit 0, given an empty FIFO.
REQ-023 sck edges detected in IDLE SHALL be ignored, with no shift, count or push.
REQ-024 SHIFT->IDLE with bit counter != 0 SHALL discard the partial byte and pulse frame_err_o high for exactly one cycle; with counter = 0 no pulse.
REQ-025 Multiple bytes within one chip-select assertion SHALL each be pushed, with no gap required between them.
REQ-026 FIFO SHALL be first-in first-out with no bypass: a push into an empty FIFO is visible on valid_o the following cycle.
REQ-027 Push with FIFO full and no simultaneous pop SHALL drop the new byte, leave contents unchanged and increment ovf_cnt_o, saturating at 255.
REQ-028 Push and pop in the same cycle SHALL both take effect at any level, including full; level_o is unchanged.
REQ-029 Pop with FIFO empty SHALL have no effect; byte_o/dc_o are don't-care while valid_o = 0.
REQ-030 SPI inputs SHALL be correctly received for sck frequencies up to clk_sys_i/4 with each sck high and low phase >= 2 clk_sys_i periods.

Reset
REQ-031 Asserting rst_sys_i SHALL immediately (asynchronously) force: state IDLE, bit counter 0, shift register 0, FIFO empty, valid_o 0, level_o 0, byte_o 0, dc_o 0, frame_err_o 0, ovf_cnt_o 0.
REQ-032 Reset asserted mid-byte SHALL discard the partial byte without a frame_err_o pulse.
REQ-033 After deassertion, a chip select already low SHALL be treated as a new IDLE->SHIFT transition once the synchroniser propagates it.

Verification
REQ-034 cs_n low, send 0xA5 with dc=1 at clk/8, ready_i=1 -> one valid_o cycle with byte_o=0xA5, dc_o=1; frame_err_o stays 0.
REQ-035 Send 0x2A (dc=0) then 0x3C (dc=1) in one cs assertion, ready_i=0 -> level_o=2; pops return 0x2A/dc 0 then 0x3C/dc 1.
REQ-036 ready_i=0, send FifoDepth+3 bytes -> level_o=4, ovf_cnt_o=3, FIFO holds the first 4 bytes in order.
REQ-037 Send 5 bits then release cs_n -> one-cycle frame_err_o pulse, level_o=0; the next full byte is received correctly.
REQ-038 FIFO full and ready_i=1 while a byte completes -> pop and push in the same cycle, level_o stays 4, ovf_cnt_o unchanged.
REQ-039 Assert rst_sys_i after 4 bits of a byte, release, then send 0x81 -> only 0x81 is received, frame_err_o never pulses.

Source files
------------

// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx
// Receives LCD bytes from a mode-0 SPI controller. The SPI pins are
// oversampled in the clk_sys_i domain. Each completed byte, together with the
// data/command flag sampled on its last bit, goes into a small FIFO.
//
// Ports
//   clk_sys_i    system clock, the only clock in the block
//   rst_sys_i    asynchronous active-high reset
//   spi_sck_i    SPI clock (CPOL=0, CPHA=0), oversampled
//   spi_cs_ni    chip select, active low
//   spi_copi_i   serial data, MSB first
//   spi_dc_i     LCD data(1)/command(0) flag, taken with bit 0 of each byte
//   byte_o       head-of-FIFO byte (0 while empty)
//   dc_o         dc flag belonging to byte_o (0 while empty)
//   valid_o      FIFO not empty
//   ready_i      consumer pops the head when valid_o && ready_i
//   level_o      FIFO occupancy
//   frame_err_o  one-cycle pulse when chip select is released mid-byte
//   ovf_cnt_o    saturating count of bytes dropped on a full FIFO
module spi_lcd_rx #(
    parameter int FifoDepth  = 4,
    parameter int SyncStages = 2
) (
    input  logic                       clk_sys_i,
    input  logic                       rst_sys_i,
    input  logic                       spi_sck_i,
    input  logic                       spi_cs_ni,
    input  logic                       spi_copi_i,
    input  logic                       spi_dc_i,
    output logic [7:0]                 byte_o,
    output logic                       dc_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(FifoDepth):0] level_o,
    output logic                       frame_err_o,
    output logic [7:0]                 ovf_cnt_o
);

    localparam int AddrW = $clog2(FifoDepth);
    localparam int LvlW  = AddrW + 1;
    localparam logic [LvlW-1:0] FullLvl = LvlW'(FifoDepth);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [SyncStages-1:0] sck_sync;
    logic [SyncStages-1:0] cs_sync;
    logic [SyncStages-1:0] copi_sync;
    logic [SyncStages-1:0] dc_sync;
    logic                  sck_s;
    logic                  cs_s;
    logic                  copi_s;
    logic                  dc_s;

    logic                  sck_d;
    logic                  sck_rise_q;
    logic                  copi_q;
    logic                  dc_q;

    state_t                state_q;
    state_t                state_d;
    logic                  enter_shift;
    logic                  abort_frame;
    logic                  shift_en;

    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic [7:0]            done_byte;
    logic                  done_dc;
    logic                  push_pend;
    logic                  frame_err_q;

    logic [8:0]            fifo_mem [FifoDepth];
    logic [AddrW-1:0]      wr_ptr;
    logic [AddrW-1:0]      rd_ptr;
    logic [LvlW-1:0]       count;
    logic                  fifo_full;
    logic                  pop;
    logic                  push_ok;
    logic [8:0]            head;

    // Input synchronisers. Chip select resets to the released level so that a
    // select already held low at reset release looks like a fresh assertion.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            copi_sync <= '0;
            dc_sync   <= '0;
        end else begin
            sck_sync  <= {sck_sync[SyncStages-2:0], spi_sck_i};
            cs_sync   <= {cs_sync[SyncStages-2:0], spi_cs_ni};
            copi_sync <= {copi_sync[SyncStages-2:0], spi_copi_i};
            dc_sync   <= {dc_sync[SyncStages-2:0], spi_dc_i};
        end
    end

    assign sck_s  = sck_sync[SyncStages-1];
    assign cs_s   = cs_sync[SyncStages-1];
    assign copi_s = copi_sync[SyncStages-1];
    assign dc_s   = dc_sync[SyncStages-1];

    // Rising-edge detector on the synchronised clock. The pulse is registered,
    // and copi/dc are registered with it, so the data bit stays aligned with
    // the edge that sampled it.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            sck_d      <= 1'b0;
            sck_rise_q <= 1'b0;
            copi_q     <= 1'b0;
            dc_q       <= 1'b0;
        end else begin
            sck_d      <= sck_s;
            sck_rise_q <= sck_s & ~sck_d;
            copi_q     <= copi_s;
            dc_q       <= dc_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Releasing the select with a partial byte in the shift
    // register flags a framing error.
    always_comb begin
        state_d     = state_q;
        enter_shift = 1'b0;
        abort_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d     = SHIFT;
                    enter_shift = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_d     = IDLE;
                    abort_frame = (bit_cnt != 3'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_en = (state_q == SHIFT) && !cs_s && sck_rise_q;

    // Shift register and bit counter. When the eighth bit arrives, the whole
    // byte and its dc flag are latched, and a push is requested for the next
    // cycle.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            done_byte   <= 8'd0;
            done_dc     <= 1'b0;
            push_pend   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_pend   <= shift_en && (bit_cnt == 3'd7);
            frame_err_q <= abort_frame;
            if (enter_shift) begin
                bit_cnt <= 3'd0;
                shreg   <= 8'd0;
            end else if (shift_en) begin
                shreg   <= {shreg[6:0], copi_q};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    done_byte <= {shreg[6:0], copi_q};
                    done_dc   <= dc_q;
                end
            end
        end
    end

    assign fifo_full = (count == FullLvl);
    assign pop       = valid_o && ready_i;
    assign push_ok   = push_pend && (!fifo_full || pop);

    // FIFO storage. It needs no reset because an empty FIFO masks the head.
    always_ff @(posedge clk_sys_i) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {done_dc, done_byte};
        end
    end

    // FIFO pointers, occupancy and overflow counter. A push into a full FIFO
    // still succeeds when the head leaves in the same cycle.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_cnt_o <= 8'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_pend && fifo_full && !pop && (ovf_cnt_o != 8'hFF)) begin
                ovf_cnt_o <= ovf_cnt_o + 8'd1;
            end
        end
    end

    assign head        = fifo_mem[rd_ptr];
    assign valid_o     = (count != '0);
    assign byte_o      = valid_o ? head[7:0] : 8'd0;
    assign dc_o        = valid_o ? head[8] : 1'b0;
    assign level_o     = count;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// tb_spi_lcd_rx
// Self-checking bench for spi_lcd_rx. It keeps a behavioural reference: a
// queue of {byte, dc} entries plus a list of bytes due to arrive, with each
// arrival scheduled from the latency rule. The reference is checked against
// the DUT on every falling clock edge. Directed checks are queued by the
// stimulus process and evaluated by the monitor process.
module tb_spi_lcd_rx;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int LVLW  = $clog2(DEPTH) + 1;

    localparam int SIG_VALID = 0;
    localparam int SIG_LEVEL = 1;
    localparam int SIG_OVF   = 2;
    localparam int SIG_BYTE  = 3;
    localparam int SIG_DC    = 4;
    localparam int SIG_FE    = 5;
    localparam int SIG_FECNT = 6;
    localparam int SIG_TB    = 7;

    logic            clk_sys_i  = 1'b0;
    logic            rst_sys_i  = 1'b1;
    logic            spi_sck_i  = 1'b0;
    logic            spi_cs_ni  = 1'b1;
    logic            spi_copi_i = 1'b0;
    logic            spi_dc_i   = 1'b0;
    logic            ready_i    = 1'b0;
    logic [7:0]      byte_o;
    logic            dc_o;
    logic            valid_o;
    logic [LVLW-1:0] level_o;
    logic            frame_err_o;
    logic [7:0]      ovf_cnt_o;

    spi_lcd_rx #(
        .FifoDepth  (DEPTH),
        .SyncStages (SYNC)
    ) dut (
        .clk_sys_i   (clk_sys_i),
        .rst_sys_i   (rst_sys_i),
        .spi_sck_i   (spi_sck_i),
        .spi_cs_ni   (spi_cs_ni),
        .spi_copi_i  (spi_copi_i),
        .spi_dc_i    (spi_dc_i),
        .byte_o      (byte_o),
        .dc_o        (dc_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .ovf_cnt_o   (ovf_cnt_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    typedef struct {
        logic [7:0] data;
        logic       dc;
    } entry_t;

    typedef struct {
        int     due;
        entry_t e;
    } pend_t;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
        logic [31:0] act;
    } req_t;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         exp_level;
        int         exp_ovf;
    } vec_t;

    entry_t model_q[$];
    pend_t  pend_q[$];
    req_t   req_q[$];
    int     pend_rd   = 0;
    int     req_rd    = 0;
    int     cyc       = 0;
    int     model_ovf = 0;
    bit     model_pop;

    int     n_vec   = 0;
    int     n_err   = 0;
    int     fe_seen = 0;
    logic   fe_prev = 1'b0;

    logic [7:0] acc           = 8'd0;
    int         bits_in_frame = 0;
    int         fe_exp        = 0;
    bit         rand_ready    = 1'b0;

    // Reference model. On each edge it pops the head if the consumer is ready,
    // then accepts whichever byte is due on this edge: into the queue when
    // there is room, otherwise it is dropped and counted.
    always @(posedge clk_sys_i or posedge rst_sys_i) begin
        cyc++;
        if (rst_sys_i) begin
            model_q.delete();
            model_ovf = 0;
            pend_rd   = pend_q.size();
        end else begin
            model_pop = (model_q.size() > 0) && (ready_i === 1'b1);
            if (model_pop) begin
                void'(model_q.pop_front());
            end
            if (pend_rd < pend_q.size()) begin
                if (pend_q[pend_rd].due == cyc) begin
                    if (model_q.size() < DEPTH) begin
                        model_q.push_back(pend_q[pend_rd].e);
                    end else if (model_ovf < 255) begin
                        model_ovf++;
                    end
                    pend_rd++;
                end
            end
        end
    end

    // Single comparison point. Only the monitor calls this, so the counters
    // have one writer.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares the DUT with the reference model on every falling
    // edge, then runs any queued directed checks.
    always @(negedge clk_sys_i) begin
        if (frame_err_o === 1'b1) begin
            fe_seen++;
            check_output("frame_err_width", {31'd0, fe_prev}, 32'd0);
        end
        fe_prev = frame_err_o;
        check_output("model_valid", {31'd0, valid_o}, {31'd0, model_q.size() != 0});
        check_output("model_level", 32'(level_o), 32'(model_q.size()));
        check_output("model_ovf", {24'd0, ovf_cnt_o}, 32'(model_ovf));
        if (model_q.size() != 0) begin
            check_output("model_byte", {24'd0, byte_o}, {24'd0, model_q[0].data});
            check_output("model_dc", {31'd0, dc_o}, {31'd0, model_q[0].dc});
        end
        while (req_rd < req_q.size()) begin
            req_t r;
            logic [31:0] a;
            r = req_q[req_rd];
            req_rd++;
            case (r.sig)
                SIG_VALID: a = {31'd0, valid_o};
                SIG_LEVEL: a = 32'(level_o);
                SIG_OVF:   a = {24'd0, ovf_cnt_o};
                SIG_BYTE:  a = {24'd0, byte_o};
                SIG_DC:    a = {31'd0, dc_o};
                SIG_FE:    a = {31'd0, frame_err_o};
                SIG_FECNT: a = 32'(fe_seen);
                default:   a = r.act;
            endcase
            check_output(r.name, a, r.exp);
        end
    end

    // Queue a check of a DUT output, evaluated at the next falling edge.
    task automatic expect_now(input string name, input int sig, input logic [31:0] exp);
        req_t r;
        r.name = name;
        r.sig  = sig;
        r.exp  = exp;
        r.act  = '0;
        req_q.push_back(r);
    endtask

    // Queue a check of a value the stimulus process has already measured.
    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        req_t r;
        r.name = name;
        r.sig  = SIG_TB;
        r.exp  = exp;
        r.act  = act;
        req_q.push_back(r);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys_i);
            #1;
            if (rand_ready) ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    // Raise sck. On every eighth bit of the frame, schedule the completed
    // byte to appear on valid_o SYNC+2 edges after the edge that first samples
    // sck high.
    task automatic raise_sck(input logic b, input logic dcv);
        pend_t p;
        spi_sck_i = 1'b1;
        acc = {acc[6:0], b};
        bits_in_frame++;
        if (bits_in_frame % 8 == 0) begin
            p.due    = cyc + SYNC + 3;
            p.e.data = acc;
            p.e.dc   = dcv;
            pend_q.push_back(p);
        end
    endtask

    task automatic send_bit(input logic b, input logic dcv, input int lo, input int hi);
        spi_sck_i  = 1'b0;
        spi_copi_i = b;
        spi_dc_i   = dcv;
        tick(lo);
        raise_sck(b, dcv);
        tick(hi);
        spi_sck_i = 1'b0;
    endtask

    // Send one byte MSB first. The dc line carries noise except on bit 0,
    // where the flag is actually taken.
    task automatic apply_stimulus(input logic [7:0] data, input logic dcv, input int lo, input int hi);
        for (int i = 7; i >= 0; i--) begin
            send_bit(data[i], (i == 0) ? dcv : 1'($urandom_range(0, 1)), lo, hi);
        end
    endtask

    task automatic cs_low();
        spi_sck_i     = 1'b0;
        spi_cs_ni     = 1'b0;
        bits_in_frame = 0;
        acc           = 8'd0;
        tick(4);
    endtask

    task automatic cs_high();
        spi_sck_i = 1'b0;
        tick(2);
        spi_cs_ni = 1'b1;
        if (bits_in_frame % 8 != 0) fe_exp++;
        tick(6);
    endtask

    // Check the head entry, then pop it.
    task automatic pop_check(input string name, input logic [7:0] eb, input logic ed);
        expect_now({name, "_valid"}, SIG_VALID, 32'd1);
        expect_now({name, "_byte"}, SIG_BYTE, {24'd0, eb});
        expect_now({name, "_dc"}, SIG_DC, {31'd0, ed});
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
    endtask

    task automatic do_reset();
        spi_sck_i = 1'b0;
        rst_sys_i = 1'b1;
        tick(3);
        rst_sys_i     = 1'b0;
        acc           = 8'd0;
        bits_in_frame = 0;
        tick(4);
    endtask

    initial begin
        vec_t       vecs [7];
        int         lat;
        logic [7:0] cap_byte;
        logic       cap_dc;
        int         nb;
        int         lo;
        int         hi;

        vecs[0] = '{data: 8'h11, dc: 1'b1, exp_level: 1, exp_ovf: 0};
        vecs[1] = '{data: 8'hE2, dc: 1'b0, exp_level: 2, exp_ovf: 0};
        vecs[2] = '{data: 8'h33, dc: 1'b1, exp_level: 3, exp_ovf: 0};
        vecs[3] = '{data: 8'h4C, dc: 1'b0, exp_level: 4, exp_ovf: 0};
        vecs[4] = '{data: 8'h55, dc: 1'b1, exp_level: 4, exp_ovf: 1};
        vecs[5] = '{data: 8'h66, dc: 1'b0, exp_level: 4, exp_ovf: 2};
        vecs[6] = '{data: 8'h7F, dc: 1'b1, exp_level: 4, exp_ovf: 3};

        // Reset state
        tick(3);
        expect_now("rst_valid", SIG_VALID, 32'd0);
        expect_now("rst_level", SIG_LEVEL, 32'd0);
        expect_now("rst_byte", SIG_BYTE, 32'd0);
        expect_now("rst_dc", SIG_DC, 32'd0);
        expect_now("rst_frame_err", SIG_FE, 32'd0);
        expect_now("rst_ovf", SIG_OVF, 32'd0);
        rst_sys_i = 1'b0;
        tick(3);

        // sck activity with the chip deselected is ignored
        for (int i = 0; i < 10; i++) begin
            spi_copi_i = 1'($urandom_range(0, 1));
            spi_sck_i  = 1'b1;
            tick(3);
            spi_sck_i = 1'b0;
            tick(3);
        end
        tick(6);
        expect_now("idle_sck_level", SIG_LEVEL, 32'd0);

        // 0xA5 data byte at clk/8 with exact valid latency and a single valid cycle
        ready_i = 1'b1;
        cs_low();
        for (int i = 7; i >= 1; i--) begin
            send_bit(1'((8'hA5 >> i) & 8'h01), 1'b0, 4, 4);
        end
        spi_copi_i = 1'b1;
        spi_dc_i   = 1'b1;
        tick(4);
        raise_sck(1'b1, 1'b1);
        @(posedge clk_sys_i);
        lat = 0;
        cap_byte = 8'h00;
        cap_dc   = 1'b0;
        while (lat < 20) begin
            @(posedge clk_sys_i);
            lat++;
            @(negedge clk_sys_i);
            if (valid_o === 1'b1) begin
                cap_byte = byte_o;
                cap_dc   = dc_o;
                break;
            end
        end
        expect_val("a5_latency", 32'(lat), 32'(SYNC + 2));
        expect_val("a5_byte", {24'd0, cap_byte}, 32'h0000_00A5);
        expect_val("a5_dc", {31'd0, cap_dc}, 32'd1);
        @(posedge clk_sys_i);
        #1;
        expect_now("a5_one_valid_cycle", SIG_VALID, 32'd0);
        spi_sck_i = 1'b0;
        cs_high();
        ready_i = 1'b0;
        expect_now("a5_no_frame_err", SIG_FECNT, 32'd0);

        // Two bytes in one selection, consumer stalled
        cs_low();
        apply_stimulus(8'h2A, 1'b0, 4, 4);
        apply_stimulus(8'h3C, 1'b1, 4, 4);
        tick(6);
        expect_now("two_bytes_level", SIG_LEVEL, 32'd2);
        pop_check("pop_2a", 8'h2A, 1'b0);
        pop_check("pop_3c", 8'h3C, 1'b1);
        cs_high();

        // Overflow table: DEPTH+3 bytes, consumer stalled
        cs_low();
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].data, vecs[i].dc, 2, 2);
            tick(6);
            expect_now($sformatf("ovf_tbl%0d_level", i), SIG_LEVEL, 32'(vecs[i].exp_level));
            expect_now($sformatf("ovf_tbl%0d_ovf", i), SIG_OVF, 32'(vecs[i].exp_ovf));
        end
        expect_now("ovf_head_byte", SIG_BYTE, {24'd0, vecs[0].data});
        expect_now("ovf_head_dc", SIG_DC, {31'd0, vecs[0].dc});

        // Full FIFO: a pop on the same edge as a push
        for (int i = 7; i >= 1; i--) begin
            send_bit(1'((8'h9D >> i) & 8'h01), 1'b1, 2, 2);
        end
        spi_copi_i = 1'b1;
        spi_dc_i   = 1'b0;
        tick(2);
        raise_sck(1'b1, 1'b0);
        tick(4);
        ready_i = 1'b1;
        tick(1);
        ready_i   = 1'b0;
        spi_sck_i = 1'b0;
        tick(1);
        expect_now("full_pushpop_level", SIG_LEVEL, 32'd4);
        expect_now("full_pushpop_ovf", SIG_OVF, 32'd3);
        pop_check("full_pop1", vecs[1].data, vecs[1].dc);
        pop_check("full_pop2", vecs[2].data, vecs[2].dc);
        pop_check("full_pop3", vecs[3].data, vecs[3].dc);
        pop_check("full_pop4", 8'h9D, 1'b0);
        tick(1);
        expect_now("full_drained", SIG_LEVEL, 32'd0);
        cs_high();

        // Five bits, then release: framing error, then a clean byte
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 3, 3);
        cs_high();
        expect_now("partial_frame_err", SIG_FECNT, 32'd1);
        expect_now("partial_level", SIG_LEVEL, 32'd0);
        cs_low();
        apply_stimulus(8'h5E, 1'b1, 3, 3);
        tick(6);
        pop_check("after_err", 8'h5E, 1'b1);
        cs_high();

        // Reset after four bits with the select held low, then 0x81
        cs_low();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 3, 3);
        do_reset();
        expect_now("midreset_byte", SIG_BYTE, 32'd0);
        expect_now("midreset_level", SIG_LEVEL, 32'd0);
        apply_stimulus(8'h81, 1'b1, 3, 3);
        tick(6);
        expect_now("midreset_level_after", SIG_LEVEL, 32'd1);
        pop_check("midreset_81", 8'h81, 1'b1);
        cs_high();
        expect_now("midreset_no_frame_err", SIG_FECNT, 32'd1);

        // Randomised traffic with a random consumer
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            cs_low();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                lo = $urandom_range(2, 5);
                hi = $urandom_range(2, 5);
                apply_stimulus(8'($urandom), 1'($urandom_range(0, 1)), lo, hi);
            end
            if ($urandom_range(0, 4) == 0) begin
                nb = $urandom_range(1, 7);
                for (int b = 0; b < nb; b++) send_bit(1'($urandom_range(0, 1)), 1'b0, 2, 3);
            end
            cs_high();
        end
        rand_ready = 1'b0;
        ready_i    = 1'b1;
        tick(12);
        ready_i = 1'b0;
        expect_now("random_drained", SIG_LEVEL, 32'd0);
        expect_now("random_frame_errs", SIG_FECNT, 32'(fe_exp));

        // Overflow counter saturation
        do_reset();
        spi_cs_ni = 1'b1;
        tick(6);
        cs_low();
        for (int i = 0; i < DEPTH + 255; i++) begin
            apply_stimulus(8'($urandom), 1'($urandom_range(0, 1)), 2, 2);
        end
        tick(6);
        expect_now("sat_ovf_255", SIG_OVF, 32'd255);
        apply_stimulus(8'hC3, 1'b1, 2, 2);
        apply_stimulus(8'h3C, 1'b0, 2, 2);
        tick(6);
        expect_now("sat_ovf_hold", SIG_OVF, 32'd255);
        expect_now("sat_level", SIG_LEVEL, 32'd4);
        cs_high();

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
